// File: rtl/rrf_commit_unit_pkg.sv
// Shared RRF sizing constants used by the commit unit and the allocator.
// Both ends import these so tag and index widths always agree.
package rrf_commit_unit_pkg;

    localparam int RRF_NUM = 64;
    localparam int RRF_SEL = 6;
    localparam int ARF_SEL = 5;

endpackage

// File: rtl/rrf_commit_select.sv
// In-order commit selection for up to two RRF entries starting at comptr.
// Purely combinational; the parent owns all storage.
module rrf_commit_select
    import rrf_commit_unit_pkg::*;
#(
    parameter int NUM = RRF_NUM,
    parameter int SEL = RRF_SEL
) (
    input  logic [SEL-1:0] comptr,
    input  logic [NUM-1:0] valid,
    input  logic [NUM-1:0] finished,
    input  logic           stall,
    output logic           c1,
    output logic           c2,
    output logic [SEL-1:0] comptr2
);

    assign comptr2 = comptr + SEL'(1);

    // Slot 2 may only retire when the head retires too.
    assign c1 = !stall && valid[comptr] && finished[comptr];
    assign c2 = c1 && valid[comptr2] && finished[comptr2];

endmodule

// File: rtl/rrf_commit_unit.sv
// Retire side of RRF entry management: tracks allocated entries and
// commits up to two finished entries per cycle in allocation order.
module rrf_commit_unit
    import rrf_commit_unit_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               dp_valid_i,
    input  logic [RRF_SEL-1:0] dp_rrftag_i,
    input  logic [ARF_SEL-1:0] dp_dstarf_i,
    input  logic               dp_dstwe_i,
    input  logic [RRF_NUM-1:0] finished_i,
    input  logic               stall_com_i,
    output logic [1:0]         com_inst_num_o,
    output logic [RRF_SEL-1:0] comptr_o,
    output logic [RRF_SEL-1:0] comptr2_o,
    output logic               arfwe1_o,
    output logic               arfwe2_o,
    output logic [ARF_SEL-1:0] dstarf1_o,
    output logic [ARF_SEL-1:0] dstarf2_o,
    output logic [RRF_SEL:0]   occupancy_o,
    output logic               nextcomcyc_o
);

    localparam int OW = RRF_SEL + 1;

    logic [RRF_NUM-1:0] valid_q;
    logic [RRF_NUM-1:0] valid_d;
    logic [ARF_SEL-1:0] dstarf_q [RRF_NUM];
    logic [RRF_NUM-1:0] dstwe_q;
    logic [RRF_SEL-1:0] comptr_q;
    logic [RRF_SEL:0]   occ_q;
    logic               wrap_q;
    logic               c1;
    logic               c2;
    logic [RRF_SEL-1:0] comptr2;
    logic [OW-1:0]      ptr_sum;

    rrf_commit_select #(
        .NUM(RRF_NUM),
        .SEL(RRF_SEL)
    ) u_sel (
        .comptr  (comptr_q),
        .valid   (valid_q),
        .finished(finished_i),
        .stall   (stall_com_i),
        .c1      (c1),
        .c2      (c2),
        .comptr2 (comptr2)
    );

    assign com_inst_num_o = c2 ? 2'd2 : {1'b0, c1};
    assign arfwe1_o       = c1 && dstwe_q[comptr_q];
    assign arfwe2_o       = c2 && dstwe_q[comptr2];
    assign dstarf1_o      = dstarf_q[comptr_q];
    assign dstarf2_o      = dstarf_q[comptr2];
    assign comptr_o       = comptr_q;
    assign comptr2_o      = comptr2;
    assign occupancy_o    = occ_q;
    assign nextcomcyc_o   = wrap_q;

    // Carry out of the extended add marks a wrap past the last tag.
    assign ptr_sum = {1'b0, comptr_q} + OW'(com_inst_num_o);

    always_comb begin
        valid_d = valid_q;
        if (c1)
            valid_d[comptr_q] = 1'b0;
        if (c2)
            valid_d[comptr2] = 1'b0;
        // Reuse of an entry freed this cycle: the new allocation wins.
        if (dp_valid_i)
            valid_d[dp_rrftag_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q  <= '0;
            comptr_q <= '0;
            occ_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            comptr_q <= ptr_sum[RRF_SEL-1:0];
            occ_q    <= occ_q + OW'(dp_valid_i) - OW'(com_inst_num_o);
            wrap_q   <= ptr_sum[RRF_SEL];
        end
    end

    always_ff @(posedge clk_i) begin
        if (dp_valid_i) begin
            dstarf_q[dp_rrftag_i] <= dp_dstarf_i;
            dstwe_q[dp_rrftag_i]  <= dp_dstwe_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_ni && dp_valid_i)
            assert (!valid_q[dp_rrftag_i] ||
                    (c1 && dp_rrftag_i == comptr_q) ||
                    (c2 && dp_rrftag_i == comptr2))
            else $error("dispatch to a live RRF entry");
    end

endmodule

// File: tb/tb_rrf_commit_unit.sv
// Randomized and directed bench for rrf_commit_unit against a
// queue-based model of allocation-ordered retirement.
module tb_rrf_commit_unit;
    import rrf_commit_unit_pkg::*;

    logic               clk_i = 1'b0;
    logic               reset_ni;
    logic               dp_valid_i;
    logic [RRF_SEL-1:0] dp_rrftag_i;
    logic [ARF_SEL-1:0] dp_dstarf_i;
    logic               dp_dstwe_i;
    logic [RRF_NUM-1:0] finished_i;
    logic               stall_com_i;
    logic [1:0]         com_inst_num_o;
    logic [RRF_SEL-1:0] comptr_o;
    logic [RRF_SEL-1:0] comptr2_o;
    logic               arfwe1_o;
    logic               arfwe2_o;
    logic [ARF_SEL-1:0] dstarf1_o;
    logic [ARF_SEL-1:0] dstarf2_o;
    logic [RRF_SEL:0]   occupancy_o;
    logic               nextcomcyc_o;

    rrf_commit_unit dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .dp_valid_i    (dp_valid_i),
        .dp_rrftag_i   (dp_rrftag_i),
        .dp_dstarf_i   (dp_dstarf_i),
        .dp_dstwe_i    (dp_dstwe_i),
        .finished_i    (finished_i),
        .stall_com_i   (stall_com_i),
        .com_inst_num_o(com_inst_num_o),
        .comptr_o      (comptr_o),
        .comptr2_o     (comptr2_o),
        .arfwe1_o      (arfwe1_o),
        .arfwe2_o      (arfwe2_o),
        .dstarf1_o     (dstarf1_o),
        .dstarf2_o     (dstarf2_o),
        .occupancy_o   (occupancy_o),
        .nextcomcyc_o  (nextcomcyc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int tag;
        int arf;
        bit we;
    } ent_t;

    ent_t q[$];
    int   m_head;
    int   m_alloc;
    bit   m_wrap;
    int   n_cmp;
    int   n_err;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [RRF_NUM-1:0] bit_at(input int t);
        logic [RRF_NUM-1:0] v;
        v = '0;
        v[t % RRF_NUM] = 1'b1;
        return v;
    endfunction

    function automatic int predicted_commits(input logic [RRF_NUM-1:0] fin,
                                             input bit stall);
        int n;
        n = 0;
        if (!stall && q.size() > 0 && fin[q[0].tag]) begin
            n = 1;
            if (q.size() > 1 && fin[q[1].tag])
                n = 2;
        end
        return n;
    endfunction

    // One cycle: drive at negedge, check combinational outputs,
    // advance the model at posedge, check registered state after.
    task automatic step(input bit dpv, input int arf, input bit we,
                        input logic [RRF_NUM-1:0] fin, input bit stall);
        int n;
        int old;
        n = predicted_commits(fin, stall);
        if (dpv && q.size() - n >= RRF_NUM)
            dpv = 1'b0;
        dp_valid_i  = dpv;
        dp_rrftag_i = RRF_SEL'(m_alloc);
        dp_dstarf_i = ARF_SEL'(arf);
        dp_dstwe_i  = we;
        finished_i  = fin;
        stall_com_i = stall;
        #1;
        check("com_num", int'(com_inst_num_o), n);
        check("comptr2", int'(comptr2_o), (m_head + 1) % RRF_NUM);
        check("arfwe1", int'(arfwe1_o), (n >= 1) ? int'(q[0].we) : 0);
        check("arfwe2", int'(arfwe2_o), (n == 2) ? int'(q[1].we) : 0);
        if (n >= 1)
            check("dstarf1", int'(dstarf1_o), q[0].arf);
        if (n == 2)
            check("dstarf2", int'(dstarf2_o), q[1].arf);
        @(posedge clk_i);
        old = m_head;
        for (int i = 0; i < n; i++)
            void'(q.pop_front());
        m_head = (old + n) % RRF_NUM;
        m_wrap = (old + n) >= RRF_NUM;
        if (dpv) begin
            q.push_back('{m_alloc, arf, we});
            m_alloc = (m_alloc + 1) % RRF_NUM;
        end
        @(negedge clk_i);
        check("comptr", int'(comptr_o), m_head);
        check("occupancy", int'(occupancy_o), q.size());
        check("nextcomcyc", int'(nextcomcyc_o), int'(m_wrap));
    endtask

    task automatic model_reset();
        q.delete();
        m_head  = 0;
        m_alloc = 0;
        m_wrap  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++)
            step(1'b0, 0, 1'b0, '1, 1'b0);
        check("drained", q.size(), 0);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset_ni    = 1'b0;
        dp_valid_i  = 1'b0;
        dp_rrftag_i = '0;
        dp_dstarf_i = '0;
        dp_dstwe_i  = 1'b0;
        finished_i  = '1;
        stall_com_i = 1'b0;
        model_reset();
        #2;
        check("rst_comptr", int'(comptr_o), 0);
        check("rst_occ", int'(occupancy_o), 0);
        check("rst_num", int'(com_inst_num_o), 0);
        check("rst_comptr2", int'(comptr2_o), 1);
        check("rst_we", int'(arfwe1_o | arfwe2_o), 0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);

        // Fill to full, then reuse tag 0 while it retires.
        for (int i = 0; i < RRF_NUM; i++)
            step(1'b1, int'($urandom_range(31)), 1'($urandom), '0, 1'b0);
        check("full_occ", int'(occupancy_o), RRF_NUM);
        step(1'b1, 9, 1'b1, bit_at(0), 1'b0);
        check("reuse_occ", int'(occupancy_o), RRF_NUM);
        check("reuse_tail", q[$].arf, 9);
        drain();

        // Asynchronous reset mid-cycle with entries live.
        for (int i = 0; i < 4; i++)
            step(1'b1, i + 1, 1'b1, '0, 1'b0);
        dp_valid_i = 1'b0;
        finished_i = '1;
        #2;
        reset_ni = 1'b0;
        #1;
        check("arst_comptr", int'(comptr_o), 0);
        check("arst_occ", int'(occupancy_o), 0);
        check("arst_num", int'(com_inst_num_o), 0);
        model_reset();
        @(negedge clk_i);
        reset_ni = 1'b1;
        step(1'b0, 0, 1'b0, '1, 1'b0);
        step(1'b0, 0, 1'b0, '1, 1'b0);

        // Single commit of tag 0.
        step(1'b1, 5, 1'b1, '0, 1'b0);
        step(1'b0, 0, 1'b0, bit_at(0), 1'b0);

        // In-order block, then dual commit.
        for (int i = 0; i < 3; i++)
            step(1'b1, 10 + i, 1'b1, '0, 1'b0);
        step(1'b0, 0, 1'b0, bit_at(m_head + 1), 1'b0);
        step(1'b0, 0, 1'b0, bit_at(m_head) | bit_at(m_head + 1), 1'b0);
        drain();

        // Stall holds a finished head for three cycles.
        step(1'b1, 7, 1'b1, '0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 0, 1'b0, bit_at(m_head), 1'b1);
        step(1'b0, 0, 1'b0, bit_at(m_head), 1'b0);

        // Walk the pointers to 63, then retire 63 and 0 together.
        for (int i = 0; i < 200 && !(m_head == RRF_NUM - 1 && q.size() == 0); i++)
            step(m_alloc != RRF_NUM - 1, 3, 1'b0, '1, 1'b0);
        check("at63", int'(comptr_o), RRF_NUM - 1);
        step(1'b1, 21, 1'b1, '0, 1'b0);
        step(1'b1, 22, 1'b1, '0, 1'b0);
        step(1'b0, 0, 1'b0, bit_at(RRF_NUM - 1) | bit_at(0), 1'b0);
        check("wrap_flag", int'(nextcomcyc_o), 1);
        step(1'b0, 0, 1'b0, '0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, int'($urandom_range(31)), 1'($urandom),
                 {$urandom, $urandom} | {$urandom, $urandom},
                 ($urandom % 8) == 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
